dma_arb: RTL and testbench

DMA_ARB -- requirements
Module: dma_arb

---
 rtl/dma_arb.sv | 122 ++++++++++++
 tb/tb_dma_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_arb.sv
// Arbiter sharing one memory port between a CPU and a USB DMA engine.
// CPU passes through when idle; DMA gets a fixed two-cycle window (access + ack).
module dma_arb #(
    parameter int l = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [l-1:0] cpu_addr,
    input  logic         cpu_r,
    input  logic [1:0]   cpu_w,
    input  logic [l-1:0] cpu_dout,
    input  logic [l-1:0] dma_addr,
    input  logic         dma_reqr,
    input  logic         dma_reqw,
    input  logic [l-1:0] dma_dout,
    output logic         dma_ack,
    output logic [l-1:0] dma_din,
    output logic [l-1:0] mem_addr,
    output logic         mem_r,
    output logic [1:0]   mem_w,
    output logic [l-1:0] mem_dout,
    input  logic [l-1:0] mem_din,
    output logic         cpu_stall
);

    // state  | meaning
    // IDLE   | CPU owns the bus; DMA waits for a free cycle or starvation limit
    // DMA_RD | DMA read access, data latched on exit
    // DMA_WR | DMA full-word write access
    // ACK    | completion pulse to requester, CPU still held off
    typedef enum logic [1:0] {IDLE, DMA_RD, DMA_WR, ACK} state_t;

    state_t       state_q, state_d;
    logic [2:0]   wait_cnt_q, wait_cnt_d;
    logic         dma_ack_q, dma_ack_d;
    logic [l-1:0] dma_din_q, dma_din_d;
    logic         cpu_stall_q, cpu_stall_d;

    logic pending;
    logic busy;
    logic grant;

    assign pending = dma_reqr | dma_reqw;
    assign busy    = cpu_r | (|cpu_w);
    assign grant   = pending & (~busy | (wait_cnt_q == 3'd4));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 3'd0;
        dma_ack_d  = 1'b0;
        dma_din_d  = dma_din_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = dma_reqr ? DMA_RD : DMA_WR;
                end else if (pending && busy) begin
                    wait_cnt_d = (wait_cnt_q == 3'd4) ? 3'd4 : wait_cnt_q + 3'd1;
                end
            end
            DMA_RD: begin
                dma_din_d = mem_din;
                dma_ack_d = 1'b1;
                state_d   = ACK;
            end
            DMA_WR: begin
                dma_ack_d = 1'b1;
                state_d   = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cpu_stall_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 3'd0;
            dma_ack_q   <= 1'b0;
            dma_din_q   <= '0;
            cpu_stall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dma_ack_q   <= dma_ack_d;
            dma_din_q   <= dma_din_d;
            cpu_stall_q <= cpu_stall_d;
        end
    end

    // Bus mux is combinational so a reset mid-access hands the bus back at once.
    always_comb begin
        mem_addr = cpu_addr;
        mem_r    = cpu_r;
        mem_w    = cpu_w;
        mem_dout = cpu_dout;
        case (state_q)
            DMA_RD: begin
                mem_addr = dma_addr;
                mem_r    = 1'b1;
                mem_w    = 2'b00;
            end
            DMA_WR: begin
                mem_addr = dma_addr;
                mem_r    = 1'b0;
                mem_w    = 2'b11;
                mem_dout = dma_dout;
            end
            ACK: begin
                mem_addr = dma_addr;
                mem_r    = 1'b0;
                mem_w    = 2'b00;
            end
            default: ;
        endcase
    end

    assign dma_ack   = dma_ack_q;
    assign dma_din   = dma_din_q;
    assign cpu_stall = cpu_stall_q;

endmodule

// File: tb/tb_dma_arb.sv
// Scoreboarded bench for dma_arb: directed DMA/CPU scenarios against a word memory model.
module tb_dma_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr, cpu_dout, dma_addr, dma_dout;
    logic        cpu_r, dma_reqr, dma_reqw;
    logic [1:0]  cpu_w;
    logic        dma_ack, mem_r, cpu_stall;
    logic [15:0] dma_din, mem_addr, mem_dout, mem_din;
    logic [1:0]  mem_w;

    logic [15:0] mem [0:65535];

    typedef struct packed {
        logic        rd;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    dma_arb #(.l(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_dout(cpu_dout),
        .dma_addr(dma_addr), .dma_reqr(dma_reqr), .dma_reqw(dma_reqw), .dma_dout(dma_dout),
        .dma_ack(dma_ack), .dma_din(dma_din),
        .mem_addr(mem_addr), .mem_r(mem_r), .mem_w(mem_w), .mem_dout(mem_dout),
        .mem_din(mem_din), .cpu_stall(cpu_stall)
    );

    always #5 clk = ~clk;

    assign mem_din = mem[mem_addr];

    always @(posedge clk) begin
        if (!reset) begin
            if (mem_w[1]) mem[mem_addr][15:8] <= mem_dout[15:8];
            if (mem_w[0]) mem[mem_addr][7:0]  <= mem_dout[7:0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack retires the oldest expected transfer.
    always @(negedge clk) begin
        if (!reset && dma_ack) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.rd) chk("ack_rd_data", {16'h0, dma_din}, {16'h0, e.data});
                else      chk("ack_wr_mem", {16'h0, mem[e.addr]}, {16'h0, e.data});
            end
        end
    end

    // One complete DMA transfer; data is write data or expected read data.
    task automatic dma_op(input logic rd, input logic [15:0] addr, input logic [15:0] data,
                          input int exp_lat);
        int lat;
        @(posedge clk); #1;
        sb_q.push_back('{rd: rd, addr: addr, data: data});
        dma_addr = addr;
        dma_dout = rd ? 16'h0 : data;
        dma_reqr = rd;
        dma_reqw = ~rd;
        lat = 0;
        @(negedge clk);
        while (!cpu_stall && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        chk("grant_latency", lat, exp_lat);
        chk("acc_mem_addr", {16'h0, mem_addr}, {16'h0, addr});
        chk("acc_mem_r", {31'h0, mem_r}, {31'h0, rd});
        chk("acc_mem_w", {30'h0, mem_w}, rd ? 32'h0 : 32'h3);
        if (!rd) chk("acc_mem_dout", {16'h0, mem_dout}, {16'h0, data});
        @(negedge clk);
        chk("ack_pulse", {31'h0, dma_ack}, 32'h1);
        chk("ack_stall", {31'h0, cpu_stall}, 32'h1);
        chk("ack_mem_w", {30'h0, mem_w}, 32'h0);
        @(posedge clk); #1;
        dma_reqr = 1'b0;
        dma_reqw = 1'b0;
        @(negedge clk);
        chk("post_stall", {31'h0, cpu_stall}, 32'h0);
        chk("post_ack", {31'h0, dma_ack}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_addr = 16'h1111; cpu_r = 1'b1; cpu_w = 2'b00; cpu_dout = 16'h0;
        dma_addr = 16'h0; dma_reqr = 1'b0; dma_reqw = 1'b0; dma_dout = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        mem[16'h5678] = 16'h1234;
        mem[16'h0100] = 16'h7777;
        reset = 1'b1;
        #3;
        chk("rst_ack", {31'h0, dma_ack}, 32'h0);
        chk("rst_din", {16'h0, dma_din}, 32'h0);
        chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
        chk("rst_pass_addr", {16'h0, mem_addr}, 32'h1111);
        chk("rst_pass_r", {31'h0, mem_r}, 32'h1);
        cpu_r = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Partial-byte CPU writes pass through untouched
        cpu_addr = 16'h0040; cpu_w = 2'b10; cpu_dout = 16'hAB00;
        @(negedge clk);
        chk("cpu_w10_mem_w", {30'h0, mem_w}, 32'h2);
        chk("cpu_w10_dout", {16'h0, mem_dout}, 32'hAB00);
        chk("cpu_w10_addr", {16'h0, mem_addr}, 32'h0040);
        chk("cpu_w10_stall", {31'h0, cpu_stall}, 32'h0);
        @(posedge clk); #1;
        cpu_w = 2'b01; cpu_dout = 16'h00CD;
        @(negedge clk);
        chk("cpu_w01_mem_w", {30'h0, mem_w}, 32'h1);
        @(posedge clk); #1;
        cpu_w = 2'b00;
        @(negedge clk);
        chk("cpu_bytes_merged", {16'h0, mem[16'h0040]}, 32'hABCD);

        // Idle-bus DMA read, then write that must not disturb dma_din
        dma_op(1'b1, 16'h5678, 16'h1234, 1);
        dma_op(1'b0, 16'h2B3C, 16'h9ABC, 1);
        chk("din_held_after_wr", {16'h0, dma_din}, 32'h1234);

        // CPU hogs the bus: starvation counter forces a grant after 4 waits
        @(posedge clk); #1;
        cpu_r = 1'b1; cpu_addr = 16'h0200;
        dma_op(1'b0, 16'h0300, 16'h4242, 5);
        chk("resume_mem_r", {31'h0, mem_r}, 32'h1);
        chk("resume_mem_addr", {16'h0, mem_addr}, 32'h0200);
        @(posedge clk); #1;
        cpu_r = 1'b0;

        // Simultaneous read and write to one address: read first
        @(posedge clk); #1;
        dma_addr = 16'h5678; dma_dout = 16'h1357;
        dma_reqr = 1'b1; dma_reqw = 1'b1;
        sb_q.push_back('{rd: 1'b1, addr: 16'h5678, data: 16'h1234});
        sb_q.push_back('{rd: 1'b0, addr: 16'h5678, data: 16'h1357});
        @(negedge clk);
        chk("both_idle_stall", {31'h0, cpu_stall}, 32'h0);
        @(negedge clk);
        chk("both_first_is_rd", {31'h0, mem_r}, 32'h1);
        chk("both_first_mem_w", {30'h0, mem_w}, 32'h0);
        @(negedge clk);
        chk("both_ack1", {31'h0, dma_ack}, 32'h1);
        @(posedge clk); #1;
        dma_reqr = 1'b0;
        @(negedge clk);
        chk("both_gap_stall", {31'h0, cpu_stall}, 32'h0);
        @(negedge clk);
        chk("both_second_mem_w", {30'h0, mem_w}, 32'h3);
        chk("both_second_dout", {16'h0, mem_dout}, 32'h1357);
        @(negedge clk);
        chk("both_ack2", {31'h0, dma_ack}, 32'h1);
        @(posedge clk); #1;
        dma_reqw = 1'b0;
        @(negedge clk);
        chk("both_done_stall", {31'h0, cpu_stall}, 32'h0);

        // Reset mid-write aborts the access without an ack
        @(posedge clk); #1;
        dma_addr = 16'h0100; dma_dout = 16'hDEAD; dma_reqw = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("abort_in_wr", {30'h0, mem_w}, 32'h3);
        #2 reset = 1'b1;
        #1;
        chk("abort_mem_w", {30'h0, mem_w}, 32'h0);
        chk("abort_stall", {31'h0, cpu_stall}, 32'h0);
        chk("abort_din", {16'h0, dma_din}, 32'h0);
        chk("abort_ack", {31'h0, dma_ack}, 32'h0);
        dma_reqw = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_mem_kept", {16'h0, mem[16'h0100]}, 32'h7777);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_ack", {31'h0, dma_ack}, 32'h0);
            @(negedge clk);
        end

        // First transfer after reset follows normal idle rules
        dma_op(1'b1, 16'h0100, 16'h7777, 1);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
